// File: rtl/add_n_check_if.sv
// ---------------------------------------------------------------------------
// add_n_check_if: handshake bundle between an add-N producer and the checker.
//
//   in_valid  producer -> checker  inps/outp hold a vector to check
//   in_ready  checker  -> producer checker accepts a vector this cycle
//   inps      producer -> checker  num_elems packed operands, element i at
//                                  inps[i*data_width +: data_width]
//   outp      producer -> checker  sum claimed by the producer
//
// master: producer side. slave: checker side.
// ---------------------------------------------------------------------------
interface add_n_check_if #(
  parameter int data_width = 2,
  parameter int num_elems  = 2
) ();

  logic                            in_valid;
  logic                            in_ready;
  logic [num_elems*data_width-1:0] inps;
  logic [data_width-1:0]           outp;

  modport master (
    output in_valid,
    output inps,
    output outp,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  inps,
    input  outp,
    output in_ready
  );

endinterface

// File: rtl/add_n_check.sv
// ---------------------------------------------------------------------------
// add_n_check: consumer/checker for the add-N stimulus interface.
//
// Accepts one vector of num_elems operands plus the producer's claimed sum,
// re-adds the operands serially (one element per cycle, modulo
// 2^data_width), then presents the result for exactly one cycle and bumps a
// saturating pass or error counter.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_if       slave side of add_n_check_if (in_valid/in_ready/inps/outp)
//   res_valid   one-cycle pulse: result below is valid
//   res_match   recomputed sum equals the captured claimed sum
//   expected    recomputed sum (0 when res_valid=0)
//   pass_count  saturating count of matching vectors
//   err_count   saturating count of mismatching vectors
//
// Timing: handshake at edge k -> res_valid in the cycle after edge
// k+num_elems -> counters updated after edge k+num_elems+1 -> next vector
// accepted no earlier than edge k+num_elems+2.
// ---------------------------------------------------------------------------
module add_n_check #(
  parameter int data_width = 2,
  parameter int num_elems  = 2,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  add_n_check_if.slave          in_if,
  output logic                  res_valid,
  output logic                  res_match,
  output logic [data_width-1:0] expected,
  output logic [cnt_width-1:0]  pass_count,
  output logic [cnt_width-1:0]  err_count
);

  localparam int IDX_W = (num_elems > 1) ? $clog2(num_elems) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(num_elems - 1);
  localparam logic [cnt_width-1:0] CNT_MAX  = {cnt_width{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_REPORT
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [data_width-1:0]           acc_q, acc_d;
  logic [num_elems*data_width-1:0] vec_q, vec_d;
  logic [data_width-1:0]           sum_q, sum_d;
  logic [cnt_width-1:0]            pass_q, pass_d;
  logic [cnt_width-1:0]            err_q, err_d;

  logic [data_width-1:0]           elem;
  logic                            is_match;

  // Operand currently being folded into the accumulator.
  assign elem     = vec_q[int'(idx_q)*data_width +: data_width];
  assign is_match = (acc_q == sum_q);

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    vec_d   = vec_q;
    sum_d   = sum_q;
    pass_d  = pass_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        // in_ready is high only here, so in_valid alone completes a handshake.
        if (in_if.in_valid) begin
          vec_d   = in_if.inps;
          sum_d   = in_if.outp;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        // Same-width add: the carry out is dropped, giving mod 2^data_width.
        acc_d = acc_q + elem;
        if (idx_q == LAST_IDX) begin
          // Park idx at 0 rather than letting it step past the last element.
          idx_d   = '0;
          state_d = ST_REPORT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_REPORT: begin
        if (is_match) begin
          if (pass_q != CNT_MAX) pass_d = pass_q + cnt_width'(1);
        end else begin
          if (err_q != CNT_MAX) err_d = err_q + cnt_width'(1);
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the captured vector and claimed sum are cleared too, so nothing
      // from an abandoned vector can leak into a later report.
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      vec_q   <= '0;
      sum_q   <= '0;
      pass_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      vec_q   <= vec_d;
      sum_q   <= sum_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: result fields are forced to 0 outside the report cycle.
  // -------------------------------------------------------------------------
  assign in_if.in_ready = (state_q == ST_IDLE);
  assign res_valid      = (state_q == ST_REPORT);
  assign res_match      = res_valid & is_match;
  assign expected       = res_valid ? acc_q : '0;
  assign pass_count     = pass_q;
  assign err_count      = err_q;

endmodule

// File: doc/add_n_check.md
Name: add_n_check

Overview:
- Consumer/checker end of the add-N stimulus interface.
- Accepts a packed vector of `num_elems` operands plus the DUT's claimed sum through a valid/ready handshake.
- Recomputes the expected sum serially, one element per cycle, then reports match/mismatch for one cycle.
- Maintains saturating pass/fail counters. Sits beside the add-N generator in self-checking benches and on-chip BIST.

Parameters:
- data_width, 2, bit width of each element and of the sum.
- num_elems, 2, number of packed elements per vector; must be >= 1.
- cnt_width, 16, width of the pass and error counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  inps/outp hold a vector to check.
- in_ready  output  1  checker can accept a vector this cycle.
- inps  input  num_elems*data_width  packed operands; element i = inps[i*data_width +: data_width].
- outp  input  data_width  sum claimed by the producer.
- res_valid  output  1  result valid, one-cycle pulse.
- res_match  output  1  computed sum equals captured outp; meaningful only when res_valid=1.
- expected  output  data_width  recomputed sum; meaningful only when res_valid=1.
- pass_count  output  cnt_width  number of matching vectors, saturating.
- err_count  output  cnt_width  number of mismatching vectors, saturating.

Behaviour:
- Reset: rst=1 at a clock edge forces the following, overriding everything else:
  - state=IDLE, idx=0, acc=0, captured vector and sum cleared.
  - res_valid=0, res_match=0, expected=0, pass_count=0, err_count=0.
  - in_ready=1 in the cycle after the edge.
- Reset mid-operation: an in-flight vector is abandoned with no report and no counter update.
- States: IDLE, ACCUM, REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge k: capture inps and outp, acc<=0, idx<=0, go to ACCUM.
  - in_valid=0 keeps the state in IDLE.
- ACCUM:
  - in_ready=0; in_valid is ignored and the producer must hold.
  - Each edge: acc <= (acc + element[idx]) mod 2^data_width, with the sum truncated to data_width bits; idx <= idx+1.
  - At the edge where idx == num_elems-1: go to REPORT. This is edge k+num_elems.
- REPORT (exactly one cycle, between edges k+num_elems and k+num_elems+1):
  - res_valid=1, expected=acc, res_match=(acc == captured outp), in_ready=0.
  - At the exit edge: pass_count increments if res_match, else err_count increments. Each counter saturates at 2^cnt_width-1 (no wrap). Then go to IDLE.
- Outputs outside REPORT: res_valid=0; res_match and expected are driven 0.
- Latency: handshake at edge k gives res_valid high in the cycle after edge k+num_elems; counters show the update after edge k+num_elems+1.
- Throughput: one vector per num_elems+2 cycles. The earliest next acceptance is edge k+num_elems+2.
- num_elems=1: ACCUM lasts one cycle; res_valid follows at edge k+1.
- idx width: clog2(num_elems), minimum 1 bit. idx never exceeds num_elems-1.
- Captured operands are unaffected by changes on inps/outp after the acceptance edge.

Test Plan:
- Match: defaults; after reset drive inps=4'b1110 (elem1=3, elem0=2) and outp=2'd1, with in_valid for one cycle → res_valid pulses exactly once, num_elems cycles after acceptance; expected=1, res_match=1; pass_count=1, err_count=0.
- Mismatch with wrap: inps=4'b1110, outp=2'd2 → expected=1, res_match=0, err_count=1. Also inps=4'b1111, outp=2'd2 → match, since 3+3=6 mod 4=2.
- Backpressure: hold in_valid=1 continuously with a new vector every cycle → in_ready is low through ACCUM and REPORT; exactly one acceptance per 4 cycles; operands changed after acceptance do not alter expected.
- Saturation: cnt_width=2; feed 5 mismatching vectors → err_count reaches 3 and stays 3; pass_count=0.
- Reset mid-operation: assert rst for one cycle during ACCUM → no res_valid pulse; counters=0; in_ready=1 next cycle; the next vector is checked correctly.
- Parameter sweep: num_elems=1, data_width=4, inps=4'd9, outp=4'd9 → res_valid one cycle after ACCUM, match. Also num_elems=4, data_width=3, elements {7,7,7,7}, outp=3'd4 → match, since 28 mod 8=4.
